// File: rtl/u109_sync_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : u109_sync_fifo_if                                            |
// | Description : Handshake bundle between U109 producer/consumer and the FWFT |
// |               FIFO. With U109_FIFO_LEVEL_EN defined it also carries the    |
// |               occupancy count.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface u109_sync_fifo_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
`ifdef U109_FIFO_LEVEL_EN
  logic [ADDR_W:0]   level;
`endif

  // User side: drives the write word and the pop request
  modport master (
    output wr_valid, wr_data, rd_valid,
    input  wr_ready, rd_ready, rd_data
`ifdef U109_FIFO_LEVEL_EN
    , input level
`endif
  );

  // FIFO side
  modport slave (
    input  wr_valid, wr_data, rd_valid,
    output wr_ready, rd_ready, rd_data
`ifdef U109_FIFO_LEVEL_EN
    , output level
`endif
  );
endinterface
`default_nettype wire

// File: rtl/u109_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : u109_sync_fifo                                               |
// | Description : Single-clock first-word-fall-through FIFO, valid/ready on    |
// |               both sides. Pointers carry an extra wrap bit so that full    |
// |               and empty are distinguishable without a counter.             |
// |               Optional macro U109_FIFO_LEVEL_EN adds a registered          |
// |               occupancy output (level).                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module u109_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  u109_sync_fifo_if.slave      bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              empty;
  logic              full;
  logic              wr_en;
  logic              rd_en;

  // Flags come only from the registered pointers; reset forces both readies low
  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    bus.wr_ready = rst_n & ~full;
    bus.rd_ready = rst_n & ~empty;
    wr_en        = bus.wr_valid & bus.wr_ready;
    rd_en        = bus.rd_valid & bus.rd_ready;
  end

  // Head word falls through combinationally; zero whenever nothing is readable
  always_comb begin
    bus.rd_data = '0;
    if (bus.rd_ready) begin
      bus.rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  // Next pointer values; natural overflow of the extra bit gives modulo 2*DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers, cleared asynchronously so the FIFO empties on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are not reset since empty pointers hide them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

`ifdef U109_FIFO_LEVEL_EN
  logic [ADDR_W:0] level_q, level_d;

  // Occupancy moves only when exactly one side of the handshake fires
  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + PTR_ONE;
      2'b01:   level_d = level_q - PTR_ONE;
      default: level_d = level_q;
    endcase
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign bus.level = level_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_u109_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_u109_sync_fifo                                            |
// | Description : Directed bench for u109_sync_fifo with a queue scoreboard.   |
// |               Level checks are compiled in with U109_FIFO_LEVEL_EN.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_u109_sync_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [DATA_W-1:0] sb [$];

  u109_sync_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  u109_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare flags/head against the scoreboard, apply the request,
  // update the scoreboard with the handshakes that the model says fire.
  task automatic cycle(input logic wv, input logic [DATA_W-1:0] wd, input logic rv);
    int  cnt;
    bit  push;
    bit  pop;
    cnt = sb.size();
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_valid = rv;
    chk("wr_ready", {63'd0, bus.wr_ready}, {63'd0, cnt != DEPTH});
    chk("rd_ready", {63'd0, bus.rd_ready}, {63'd0, cnt != 0});
    if (cnt == 0) chk("rd_data_empty", {32'd0, bus.rd_data}, 64'd0);
    else          chk("rd_data",       {32'd0, bus.rd_data}, {32'd0, sb[0]});
`ifdef U109_FIFO_LEVEL_EN
    chk("level", {59'd0, bus.level}, 64'(cnt));
`endif
    push = wv && (cnt < DEPTH);
    pop  = rv && (cnt > 0);
    if (pop)  void'(sb.pop_front());
    if (push) sb.push_back(wd);
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_valid = 1'b0;

    // Reset state
    #2;
    chk("rst_wr_ready", {63'd0, bus.wr_ready}, 64'd0);
    chk("rst_rd_ready", {63'd0, bus.rd_ready}, 64'd0);
    chk("rst_rd_data",  {32'd0, bus.rd_data},  64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write then read
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0);
    chk("basic_head", {32'd0, bus.rd_data}, 64'hA000_0000);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    chk("basic_drained", {63'd0, bus.rd_ready}, 64'd0);

    // Fill to full, then overflow attempts
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i), 1'b0);
    chk("full_wr_ready", {63'd0, bus.wr_ready}, 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hDEAD, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
    chk("full_drained", {63'd0, bus.rd_ready}, 64'd0);

    // Empty guard
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'h55, 1'b0);
    chk("guard_rd_ready", {63'd0, bus.rd_ready}, 64'd1);
    chk("guard_rd_data",  {32'd0, bus.rd_data},  64'h55);
`ifdef U109_FIFO_LEVEL_EN
    chk("guard_level", {59'd0, bus.level}, 64'd1);
`endif
    cycle(1'b0, '0, 1'b1);

    // Simultaneous write/pop with pointer wrap
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 4; i < 44; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b1);
    chk("wrap_head", {32'd0, bus.rd_data}, 64'h128);
`ifdef U109_FIFO_LEVEL_EN
    chk("wrap_level", {59'd0, bus.level}, 64'd4);
`endif
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

    // Async reset mid-operation
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_ready", {63'd0, bus.wr_ready}, 64'd0);
    chk("mid_rst_rd_ready", {63'd0, bus.rd_ready}, 64'd0);
    chk("mid_rst_rd_data",  {32'd0, bus.rd_data},  64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_wr_ready", {63'd0, bus.wr_ready}, 64'd1);
    chk("post_rst_rd_ready", {63'd0, bus.rd_ready}, 64'd0);
    cycle(1'b1, 32'h1234, 1'b0);
    chk("post_rst_first", {32'd0, bus.rd_data}, 64'h1234);
    cycle(1'b0, '0, 1'b1);

    // Full with simultaneous pop: pop accepted, write rejected
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0);
    cycle(1'b1, 32'hBEEF, 1'b1);
    chk("full_pop_wr_ready", {63'd0, bus.wr_ready}, 64'd1);
    chk("full_pop_head",     {32'd0, bus.rd_data},  64'h301);
`ifdef U109_FIFO_LEVEL_EN
    chk("full_pop_level", {59'd0, bus.level}, 64'd15);
`endif
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/u109_sync_fifo.md
Name: u109_sync_fifo

Overview:
- Single-clock first-word-fall-through (FWFT) FIFO buffering 32-bit words between a producer and a consumer inside U109.
- Both sides use valid/ready handshakes.
- Storage is a register or distributed-RAM array addressed by wrap-around pointers.
- Provides full and empty back-pressure, so words are never overwritten and never read from an empty FIFO.

Parameters:
DATA_W, 32, word width in bits
DEPTH, 16, number of entries; must be a power of two and at least 2
ADDR_W, $clog2(DEPTH) = 4, derived localparam; not overridable

Ports:
clk  input  1  single clock for all logic, rising edge
rst_n  input  1  reset, asynchronous and active-low
wr_valid  input  1  producer presents wr_data this cycle
wr_data  input  DATA_W  write word
wr_ready  output  1  FIFO can accept a word (not full)
rd_valid  input  1  consumer pops the head word this cycle
rd_ready  output  1  FIFO holds at least one word (not empty)
rd_data  output  DATA_W  head word (FWFT)
level  output  ADDR_W+1  occupancy 0..DEPTH; present only with U109_FIFO_LEVEL_EN

Behaviour:
- Reset:
  - rst_n low asynchronously clears wr_ptr, rd_ptr (ADDR_W+1 bits each) and level.
  - While rst_n is low: wr_ready=0, rd_ready=0, rd_data=0.
  - Memory contents are not reset.
  - wr_ready rises combinationally once rst_n is high and the FIFO is not full.
- Pointers:
  - ADDR_W+1 bits each; the MSB is the wrap bit.
  - Address = lower ADDR_W bits.
  - Pointers increment modulo 2*DEPTH.
- Flags, from registered pointers only:
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the lower bits are equal.
  - wr_ready = rst_n & ~full.
  - rd_ready = rst_n & ~empty.
- Write:
  - On a clk rising edge with wr_valid & wr_ready: mem[wr_ptr[ADDR_W-1:0]] <= wr_data, then wr_ptr++.
  - wr_valid while full is ignored: no pointer change, no data corruption.
- Read:
  - rd_data = mem[rd_ptr[ADDR_W-1:0]] whenever rd_ready=1, else 0.
  - Valid in the same cycle rd_ready is high; no read latency.
  - On a clk rising edge with rd_valid & rd_ready, rd_ptr++ and the next word appears on rd_data after that edge.
  - rd_valid while empty is ignored.
- Write-to-read latency: a word written at edge N is visible on rd_data, with rd_ready=1, immediately after edge N if the FIFO was empty.
- Simultaneous write and pop:
  - Both occur in the same edge when both handshakes are valid; occupancy is unchanged.
  - When full, a pop in the same cycle does not enable a write (wr_ready is already 0).
  - When empty, a write in the same cycle does not allow a pop (rd_ready is already 0).
- Ordering: strict FIFO order. Wrap-around is transparent to the user.
- Reset mid-operation: all contents are discarded; the FIFO is empty after reset.

Optional Feature:
- Macro: U109_FIFO_LEVEL_EN.
- When defined:
  - Adds output level[ADDR_W:0], a registered occupancy count.
  - Update rule: +1 on write only, −1 on pop only, unchanged on both or neither.
  - Reset value is 0. level == DEPTH exactly when full.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Basic write then read:
  - Stimulus: release reset; write 8 words 0xA0000000..0xA0000007 on consecutive clocks; idle 10 clocks; pop 8 words.
  - Response: rd_data reads 0xA0000000..0xA0000007 in order. rd_ready=0 after the 8th pop; wr_ready=1 throughout.
- Fill to full:
  - Stimulus: write 16 words 0x0..0xF; then hold wr_valid with 0xDEAD for 3 clocks.
  - Response: wr_ready=0 after the 16th write. The 17th write is dropped. Popping 16 words yields 0x0..0xF; rd_ready then drops to 0.
- Empty guard:
  - Stimulus: assert rd_valid for 5 clocks on an empty FIFO; then write 0x55.
  - Response: rd_ready=0 and rd_data=0 while empty. After the write edge, rd_ready=1 and rd_data=0x55. With the macro, level=1.
- Simultaneous and wrap:
  - Stimulus: preload 4 words; then for 40 clocks write an incrementing value and pop every cycle.
  - Response: occupancy stays 4 (level=4 with the macro). Pointers wrap at least twice. Every pop returns values in strict write order with no loss.
- Async reset mid-operation:
  - Stimulus: preload 6 words; assert rst_n low between clock edges.
  - Response: wr_ready=0, rd_ready=0, rd_data=0 immediately. After release, the FIFO is empty, wr_ready=1, and a new write of 0x1234 reads back first.
- Full with simultaneous pop:
  - Stimulus: with the FIFO full, assert wr_valid and rd_valid together for 1 cycle.
  - Response: the pop succeeds and the write is rejected. The FIFO is not full afterwards (wr_ready=1; level=15 with the macro).
